dna_port_reader: RTL and testbench

- Reads the FPGA device DNA serially from the DNA_PORT primitive and presents it as a parallel word.
- Sits directly upstream of the NIDNAPort AXI4-Lite register slave, which latches dna_out/dna_valid into its read-only registers.
- Generates the slow primitive clock and the READ/SHIFT controls, and performs one read automatically after reset or on request.

---
 rtl/dna_port_reader_if.sv | 42 ++++
 rtl/dna_port_reader.sv | 140 ++++++++++++++
 tb/tb_dna_port_reader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dna_port_reader_if.sv
// Bundle of the DNA_PORT pins and the parallel result/handshake side of the reader.
// Latency: none, wires only.
// Backpressure: none; start is a request that is dropped while the reader is busy.
interface dna_port_reader_if #(
    parameter int DNA_WIDTH = 57
);
    logic                 start;
    logic                 busy;
    logic                 dna_valid;
    logic [DNA_WIDTH-1:0] dna_out;
    logic                 dna_clk;
    logic                 dna_read;
    logic                 dna_shift;
    logic                 dna_din;
    logic                 dna_dout;

    // Reader side: drives the primitive controls and the parallel result.
    modport master (
        input  start,
        input  dna_dout,
        output busy,
        output dna_valid,
        output dna_out,
        output dna_clk,
        output dna_read,
        output dna_shift,
        output dna_din
    );

    // Environment side: requester plus the DNA_PORT primitive itself.
    modport slave (
        output start,
        output dna_dout,
        input  busy,
        input  dna_valid,
        input  dna_out,
        input  dna_clk,
        input  dna_read,
        input  dna_shift,
        input  dna_din
    );
endinterface

// File: rtl/dna_port_reader.sv
// Serially reads the device DNA from DNA_PORT and presents it as a parallel word.
// Latency: launch cycle to dna_valid is 1 + 2*CLK_DIV*DNA_WIDTH ACLK cycles.
// Backpressure: start is ignored while busy or in the completion cycle; no queueing.
module dna_port_reader #(
    parameter int DNA_WIDTH  = 57,
    parameter int CLK_DIV    = 2,
    parameter int AUTO_START = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    dna_port_reader_if.master     bus
);
    localparam int BW = $clog2(DNA_WIDTH);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DNA_WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CLK_HIGH = 2'd1,
        S_CLK_LOW  = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DNA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DNA_WIDTH-1:0] out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 clk_q, clk_d;
    logic                 read_q, read_d;
    logic                 shift_q, shift_d;
    logic                 first_q, first_d;

    // State register; first_q marks the first cycle after reset for the auto-read.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            clk_q   <= 1'b0;
            read_q  <= 1'b0;
            shift_q <= 1'b0;
            first_q <= (AUTO_START != 0);
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            clk_q   <= clk_d;
            read_q  <= read_d;
            shift_q <= shift_d;
            first_q <= first_d;
        end
    end

    // Next-state logic. dna_clk is registered from the previous state, so it lags
    // the FSM by one cycle; READ/SHIFT are registered on entry to CLK_HIGH and are
    // therefore already stable one cycle before the primitive sees its rising edge.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        out_d   = out_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        read_d  = read_q;
        shift_d = shift_q;
        first_d = 1'b0;
        clk_d   = (state_q == S_CLK_HIGH);

        case (state_q)
            S_IDLE: begin
                if (bus.start || first_q) begin
                    state_d = S_CLK_HIGH;
                    div_d   = '0;
                    bit_d   = '0;
                    shreg_d = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    read_d  = 1'b1;
                    shift_d = 1'b0;
                end
            end
            S_CLK_HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_CLK_LOW;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_CLK_LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    shreg_d = {shreg_q[DNA_WIDTH-2:0], bus.dna_dout};
                    if (bit_q == BIT_LAST) begin
                        state_d = S_DONE;
                        out_d   = shreg_d;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        read_d  = 1'b0;
                        shift_d = 1'b0;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        state_d = S_CLK_HIGH;
                        read_d  = 1'b0;
                        shift_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.dna_valid = valid_q;
    assign bus.dna_out   = out_q;
    assign bus.dna_clk   = clk_q;
    assign bus.dna_read  = read_q;
    assign bus.dna_shift = shift_q;
    assign bus.dna_din   = 1'b0;
endmodule

// File: tb/tb_dna_port_reader.sv
// Directed bench for dna_port_reader: two instances (default and CLK_DIV=1/no auto-start).
// Latency: checks exact launch-to-valid cycle counts against hand-computed values.
// Backpressure: exercises start while busy, start on the completion cycle, and mid-read reset.
module tb_dna_port_reader;
    localparam logic [56:0] V1 = 57'h1_23456789ABCDEF;
    localparam logic [56:0] V2 = 57'h0_FFFF0000FFFF00;
    localparam logic [56:0] V3 = 57'h1_5A5A5A5A5A5A5A;
    localparam logic [56:0] V4 = 57'h1_0F1E2D3C4B5A69;

    logic aclk = 1'b0;
    logic areset;
    logic start_a, start_b;
    logic [56:0] val_a, val_b;
    logic [56:0] m_a = '0;
    logic [56:0] m_b = '0;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    dna_port_reader_if #(.DNA_WIDTH(57)) ifa ();
    dna_port_reader_if #(.DNA_WIDTH(57)) ifb ();

    dna_port_reader #(.DNA_WIDTH(57), .CLK_DIV(2), .AUTO_START(1)) u_a (
        .ACLK(aclk), .ARESET(areset), .bus(ifa)
    );
    dna_port_reader #(.DNA_WIDTH(57), .CLK_DIV(1), .AUTO_START(0)) u_b (
        .ACLK(aclk), .ARESET(areset), .bus(ifb)
    );

    assign ifa.start    = start_a;
    assign ifb.start    = start_b;
    assign ifa.dna_dout = m_a[56];
    assign ifb.dna_dout = m_b[56];

    // DNA_PORT models: READ loads the ID, SHIFT moves towards DOUT, DOUT = MSB.
    always @(posedge ifa.dna_clk) begin
        if (ifa.dna_read)       m_a <= val_a;
        else if (ifa.dna_shift) m_a <= {m_a[55:0], ifa.dna_din};
    end
    always @(posedge ifb.dna_clk) begin
        if (ifb.dna_read)       m_b <= val_b;
        else if (ifb.dna_shift) m_b <= {m_b[55:0], ifb.dna_din};
    end

    // Protocol monitor for instance A; per-read counters restart when busy rises.
    int r_edges = 0, r_read = 0, r_shift = 0, r_first_ok = 0;
    int r_viol = 0, r_hi_bad = 0, r_lo_bad = 0;
    int hrun = 0, lrun = 0;
    bit lo_valid = 1'b0;
    logic p_clk = 1'b0, p_read = 1'b0, p_shift = 1'b0, p_busy = 1'b0;
    always @(negedge aclk) begin
        if (ifa.busy && !p_busy) begin
            r_edges = 0; r_read = 0; r_shift = 0; r_first_ok = 0;
            r_viol = 0; r_hi_bad = 0; r_lo_bad = 0; lo_valid = 1'b0;
        end
        if (ifa.dna_clk) begin
            if (!p_clk) begin
                r_edges++;
                if (ifa.dna_read)  r_read++;
                if (ifa.dna_shift) r_shift++;
                if (r_edges == 1 && ifa.dna_read && !ifa.dna_shift) r_first_ok = 1;
                if (lo_valid && lrun != 2) r_lo_bad++;
                lo_valid = 1'b0;
                hrun = 0;
            end
            hrun++;
            if (ifa.dna_read !== p_read || ifa.dna_shift !== p_shift) r_viol++;
        end else begin
            if (p_clk) begin
                if (hrun != 2) r_hi_bad++;
                lrun = 0;
                lo_valid = ifa.busy;
            end
            lrun++;
        end
        if (!ifa.busy) lo_valid = 1'b0;
        p_clk = ifa.dna_clk; p_read = ifa.dna_read;
        p_shift = ifa.dna_shift; p_busy = ifa.busy;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on the launch cycle (start already driven or reset just released).
    // Counts cycles until dna_valid, bounded; optionally pulses start mid-read.
    task automatic run_read(input bit use_b, input int pulse_at,
                            output int n, output int busy_bad,
                            output int out_chg, output logic first_valid);
        logic [56:0] out0;
        logic v, b;
        logic [56:0] o;
        out0 = use_b ? ifb.dna_out : ifa.dna_out;
        n = 0; busy_bad = 0; out_chg = 0; first_valid = 1'bx;
        while (n < 400) begin
            @(negedge aclk);
            n++;
            if (n == 1) begin start_a = 1'b0; start_b = 1'b0; end
            if (n == pulse_at) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end else if (n == pulse_at + 1) begin
                start_a = 1'b0; start_b = 1'b0;
            end
            v = use_b ? ifb.dna_valid : ifa.dna_valid;
            b = use_b ? ifb.busy : ifa.busy;
            o = use_b ? ifb.dna_out : ifa.dna_out;
            if (n == 1) first_valid = v;
            if (v) begin
                if (b) busy_bad++;
                break;
            end
            if (!b) busy_bad++;
            if (o !== out0) out_chg++;
        end
    endtask

    initial begin
        int n, bb, oc;
        logic fv;
        areset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        val_a = V1; val_b = V4;
        repeat (3) @(negedge aclk);

        chk("rst_ctrl_a", {ifa.busy, ifa.dna_valid, ifa.dna_clk, ifa.dna_read, ifa.dna_shift, ifa.dna_din}, 6'b0);
        chk("rst_out_a", ifa.dna_out, 57'h0);
        chk("rst_b", {ifb.busy, ifb.dna_valid, ifb.dna_clk, ifb.dna_read, ifb.dna_shift, ifb.dna_out}, 62'h0);

        // Auto-read after reset release.
        areset = 1'b0;
        run_read(1'b0, -1, n, bb, oc, fv);
        chk("auto_latency", n, 229);
        chk("auto_busy", bb, 0);
        chk("auto_value", ifa.dna_out, V1);
        chk("b_idle_noauto", {ifb.busy, ifb.dna_valid}, 2'b00);
        chk("edges", r_edges, 57);
        chk("read_edges", r_read, 1);
        chk("read_first", r_first_ok, 1);
        chk("shift_edges", r_shift, 56);
        chk("ctl_stable", r_viol, 0);
        chk("clk_high_len", r_hi_bad, 0);
        chk("clk_low_len", r_lo_bad, 0);
        @(negedge aclk);
        chk("valid_level", {ifa.dna_valid, ifa.busy}, 2'b10);

        // Re-read on request with a new ID; old value held while busy.
        val_a = V2;
        repeat (3) @(negedge aclk);
        start_a = 1'b1;
        run_read(1'b0, -1, n, bb, oc, fv);
        chk("valid_drop", fv, 1'b0);
        chk("out_held", oc, 0);
        chk("req_latency", n, 229);
        chk("req_value", ifa.dna_out, V2);

        // start while busy is ignored.
        repeat (2) @(negedge aclk);
        start_a = 1'b1;
        run_read(1'b0, 50, n, bb, oc, fv);
        chk("busy_start_latency", n, 229);
        chk("busy_start_edges", r_edges, 57);
        chk("busy_start_value", ifa.dna_out, V2);

        // Reset at cycle 100 of a read, then the auto-read afterwards.
        val_a = V3;
        repeat (2) @(negedge aclk);
        start_a = 1'b1;
        @(negedge aclk);
        start_a = 1'b0;
        repeat (99) @(negedge aclk);
        areset = 1'b1;
        #1;
        chk("midrst_ctrl", {ifa.busy, ifa.dna_valid, ifa.dna_clk, ifa.dna_read, ifa.dna_shift, ifa.dna_din}, 6'b0);
        chk("midrst_out", ifa.dna_out, 57'h0);
        @(negedge aclk);
        areset = 1'b0;
        run_read(1'b0, -1, n, bb, oc, fv);
        chk("rearm_latency", n, 229);
        chk("rearm_value", ifa.dna_out, V3);
        chk("rearm_edges", r_edges, 57);

        // Instance B: CLK_DIV=1, no auto-start.
        chk("b_still_idle", {ifb.busy, ifb.dna_valid, ifb.dna_out}, 59'h0);
        start_b = 1'b1;
        run_read(1'b1, -1, n, bb, oc, fv);
        chk("b_latency", n, 115);
        chk("b_value", ifb.dna_out, V4);
        chk("b_busy", bb, 0);
        // Start presented during the completion cycle is dropped.
        start_b = 1'b1;
        @(negedge aclk);
        start_b = 1'b0;
        chk("b_done_start_ignored", {ifb.busy, ifb.dna_valid}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
